dogruluk_tarayici: RTL and testbench

Sequencer that drives the shared 4-input function inputs (A, B, C, D) through all 16 combinations and samples the outputs of two implementations of the same function: the simplified SOP form and the expanded minterm form. It records the simplified-form truth table, counts vectors where the two forms disagree, and reports the first disagreeing vector. It sits between a start/status register interface and the two combinational function instances. It replaces the manual exhaustive stimulus sweep with a repeatable, self-checking scan.

---
 rtl/dogruluk_tarayici_if.sv | 33 +++
 rtl/dogruluk_tarayici.sv | 156 +++++++++++++++
 tb/tb_dogruluk_tarayici.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dogruluk_tarayici_if.sv
// Bundle of the scan control/status signals and the function-under-test
// vector/sample lines used by dogruluk_tarayici.
//   master: the side that issues start/hold and supplies OUT_S/OUT_E
//   slave : the scanner itself (drives A..D and all status outputs)
interface dogruluk_tarayici_if;
    logic        start;
    logic        hold;
    logic        OUT_S;
    logic        OUT_E;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        busy;
    logic        done;
    logic        pass;
    logic        result_valid;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    logic [15:0] truth_tbl;

    modport master (
        output start, hold, OUT_S, OUT_E,
        input  A, B, C, D, busy, done, pass, result_valid,
               mismatch_cnt, first_fail, truth_tbl
    );

    modport slave (
        input  start, hold, OUT_S, OUT_E,
        output A, B, C, D, busy, done, pass, result_valid,
               mismatch_cnt, first_fail, truth_tbl
    );
endinterface

// File: rtl/dogruluk_tarayici.sv
// dogruluk_tarayici: exhaustive truth-table scanner. Steps {A,B,C,D} through
// all 16 vectors, waits SETTLE_CYC cycles per vector, then samples the
// simplified-form (OUT_S) and expanded-form (OUT_E) outputs. Records the
// OUT_S truth table, counts disagreeing vectors and remembers the first one.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every output
//   bus    - dogruluk_tarayici_if.slave: start/hold in, OUT_S/OUT_E in,
//            A..D vector out, busy/done/pass/result_valid, mismatch_cnt,
//            first_fail, truth_tbl out
// Parameter:
//   SETTLE_CYC - idle cycles between driving a vector and sampling it (0..15)
// Build option:
//   SCAN_STOP_ON_FAIL_EN - when defined, the first mismatch ends the scan.
module dogruluk_tarayici #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dogruluk_tarayici_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    // With no settle time the scanner goes straight to sampling.
    localparam state_t     FIRST_ST    = (SETTLE_CYC == 0) ? SAMPLE : WAIT;
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic        busy_r;
    logic        done_r;
    logic        rv_r;
    logic [4:0]  mcnt;
    logic [3:0]  ff_idx;
    logic [15:0] tbl;

    logic        accept;
    logic        capture;
    logic        finish;
    logic        mismatch;
    logic        stop_scan;

    assign mismatch = (bus.OUT_S != bus.OUT_E);

`ifdef SCAN_STOP_ON_FAIL_EN
    assign stop_scan = mismatch;
`else
    assign stop_scan = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // hold gates every transition, so start is ignored while hold is high.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        if (!bus.hold) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        accept    = 1'b1;
                        state_nxt = FIRST_ST;
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_nxt = SAMPLE;
                    end
                end
                SAMPLE: begin
                    capture = 1'b1;
                    if ((idx == 4'd15) || stop_scan) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FIRST_ST;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath freezes entirely under hold, done included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rv_r       <= 1'b0;
            mcnt       <= '0;
            ff_idx     <= '0;
            tbl        <= '0;
        end else if (!bus.hold) begin
            done_r <= finish;
            if (accept) begin
                idx        <= '0;
                settle_cnt <= '0;
                busy_r     <= 1'b1;
                rv_r       <= 1'b0;
                mcnt       <= '0;
                ff_idx     <= '0;
                tbl        <= '0;
            end
            if (state == WAIT) begin
                settle_cnt <= (settle_cnt == SETTLE_LAST) ? 4'd0 : settle_cnt + 4'd1;
            end
            if (capture) begin
                tbl[idx] <= bus.OUT_S;
                if (mismatch) begin
                    mcnt <= mcnt + 5'd1;
                    if (mcnt == 5'd0) begin
                        ff_idx <= idx;
                    end
                end
                if (finish) begin
                    rv_r   <= 1'b1;
                    busy_r <= 1'b0;
                end else begin
                    idx        <= idx + 4'd1;
                    settle_cnt <= '0;
                end
            end
        end
    end

    assign bus.A            = idx[3];
    assign bus.B            = idx[2];
    assign bus.C            = idx[1];
    assign bus.D            = idx[0];
    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.result_valid = rv_r;
    assign bus.pass         = rv_r && (mcnt == 5'd0);
    assign bus.mismatch_cnt = mcnt;
    assign bus.first_fail   = ff_idx;
    assign bus.truth_tbl    = tbl;

endmodule

// File: tb/tb_dogruluk_tarayici.sv
// Directed bench for dogruluk_tarayici. Two instances: SETTLE_CYC=1 (main)
// and SETTLE_CYC=0. OUT_S/OUT_E come from small models of the simplified
// (A~B | ABC | C~D) and expanded (minterms 2,4,5,6,7,10,14,15) forms.
module tb_dogruluk_tarayici;

`ifdef SCAN_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    localparam int          LAT1     = STOP ? 10 : 32;
    localparam int          LAT0     = STOP ? 5 : 16;
    localparam logic [15:0] EXP_TBL  = STOP ? 16'h0004 : 16'hCF44;
    localparam int          EXP_MC   = STOP ? 1 : 6;
    localparam int          EXP_LAST = STOP ? 4 : 15;
    localparam int          RST_AT   = STOP ? 3 : 9;

    logic clk;
    logic rst_n;
    logic tie;
    int   cyc;
    int   t0;
    int   passed;
    int   fails;
    int   total;

    dogruluk_tarayici_if bus0();
    dogruluk_tarayici_if bus1();

    dogruluk_tarayici #(.SETTLE_CYC(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    dogruluk_tarayici #(.SETTLE_CYC(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic f_s(input logic [3:0] v);
        return (v[3] & ~v[2]) | (v[3] & v[2] & v[1]) | (v[1] & ~v[0]);
    endfunction

    function automatic logic f_e(input logic [3:0] v);
        case (v)
            4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd14, 4'd15: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    logic [3:0] v0;
    logic [3:0] v1;
    assign v0 = {bus0.A, bus0.B, bus0.C, bus0.D};
    assign v1 = {bus1.A, bus1.B, bus1.C, bus1.D};

    assign bus0.OUT_S = f_s(v0);
    assign bus0.OUT_E = tie ? f_s(v0) : f_e(v0);
    assign bus1.OUT_S = f_s(v1);
    assign bus1.OUT_E = tie ? f_s(v1) : f_e(v1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [15:0] tbl, input logic [4:0] mc,
                           input logic [3:0] ff, input logic ps, input logic rv, input logic bsy,
                           input logic [15:0] e_tbl, input int e_mc, input int e_ff, input logic e_ps);
        chk({tag, "_tbl"},  32'(tbl), 32'(e_tbl));
        chk({tag, "_mc"},   32'(mc),  32'(e_mc));
        chk({tag, "_ff"},   32'(ff),  32'(e_ff));
        chk({tag, "_pass"}, 32'(ps),  32'(e_ps));
        chk({tag, "_rv"},   32'(rv),  32'd1);
        chk({tag, "_busy"}, 32'(bsy), 32'd0);
    endtask

    // Called at #1 after an edge; start is accepted on the next edge.
    task automatic start_scan(input bit which);
        if (which) bus1.start = 1'b1;
        else       bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input bit which, input string tag, input int exp_lat);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if ((which ? bus1.done : bus0.done) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit reached;
        passed = 0;
        fails  = 0;
        total  = 0;
        tie    = 1'b0;
        rst_n  = 1'b0;
        bus0.start = 1'b0;
        bus0.hold  = 1'b0;
        bus1.start = 1'b0;
        bus1.hold  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_pass", 32'(bus0.pass), 32'd0);
        chk("rst_rv",   32'(bus0.result_valid), 32'd0);
        chk("rst_mc",   32'(bus0.mismatch_cnt), 32'd0);
        chk("rst_ff",   32'(bus0.first_fail), 32'd0);
        chk("rst_tbl",  32'(bus0.truth_tbl), 32'd0);
        chk("rst_abcd", 32'(v0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full scan, both forms as specified
        start_scan(1'b0);
        chk("t1_busy", 32'(bus0.busy), 32'd1);
        chk("t1_idx0", 32'(v0), 32'd0);
        wait_done(1'b0, "t1", LAT1);
        chk_res("t1", bus0.truth_tbl, bus0.mismatch_cnt, bus0.first_fail, bus0.pass,
                bus0.result_valid, bus0.busy, EXP_TBL, EXP_MC, 4, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_done_pulse", 32'(bus0.done), 32'd0);
        chk("t1_nowrap", 32'(v0), 32'(EXP_LAST));

        // hold and start together in IDLE: start ignored
        bus0.hold  = 1'b1;
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.hold  = 1'b0;
        bus0.start = 1'b0;
        chk("holdstart_busy", 32'(bus0.busy), 32'd0);
        chk("holdstart_rv", 32'(bus0.result_valid), 32'd1);
        @(posedge clk);
        #1;
        chk("holdstart_busy2", 32'(bus0.busy), 32'd0);

        // OUT_E tied to OUT_S
        tie = 1'b1;
        start_scan(1'b0);
        chk("t2_rv_clr", 32'(bus0.result_valid), 32'd0);
        wait_done(1'b0, "t2", 32);
        chk_res("t2", bus0.truth_tbl, bus0.mismatch_cnt, bus0.first_fail, bus0.pass,
                bus0.result_valid, bus0.busy, 16'hCF44, 0, 0, 1'b1);
        tie = 1'b0;
        @(posedge clk);
        #1;

        // hold for 7 cycles mid-scan, then a start while busy
        start_scan(1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus0.hold = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("t3_hold_idx", 32'(v0), 32'd2);
        chk("t3_hold_busy", 32'(bus0.busy), 32'd1);
        bus0.hold  = 1'b0;
        bus0.start = 1'b1;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        wait_done(1'b0, "t3", LAT1 + 7);
        chk_res("t3", bus0.truth_tbl, bus0.mismatch_cnt, bus0.first_fail, bus0.pass,
                bus0.result_valid, bus0.busy, EXP_TBL, EXP_MC, 4, 1'b0);
        @(posedge clk);
        #1;

        // Reset mid-scan, then a clean rescan
        start_scan(1'b0);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (v0 == 4'(RST_AT)) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("t4_reached", 32'(reached), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy", 32'(bus0.busy), 32'd0);
        chk("t4_rst_abcd", 32'(v0), 32'd0);
        chk("t4_rst_mc",   32'(bus0.mismatch_cnt), 32'd0);
        chk("t4_rst_tbl",  32'(bus0.truth_tbl), 32'd0);
        chk("t4_rst_pass", 32'(bus0.pass), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_scan(1'b0);
        chk("t4_idx0", 32'(v0), 32'd0);
        wait_done(1'b0, "t4", LAT1);
        chk_res("t4", bus0.truth_tbl, bus0.mismatch_cnt, bus0.first_fail, bus0.pass,
                bus0.result_valid, bus0.busy, EXP_TBL, EXP_MC, 4, 1'b0);
        @(posedge clk);
        #1;

        // SETTLE_CYC=0 instance: one vector per cycle
        start_scan(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_idx3", 32'(v1), 32'd3);
        wait_done(1'b1, "t5", LAT0);
        chk_res("t5", bus1.truth_tbl, bus1.mismatch_cnt, bus1.first_fail, bus1.pass,
                bus1.result_valid, bus1.busy, EXP_TBL, EXP_MC, 4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
